// File: rtl/c2c_r_arbiter.sv
// c2c_r_arbiter: two-master / one-slave arbiter for the c2c_r read bus.
// Master 0 is the instruction fetch unit, master 1 is the load path.
// A grant is held for exactly one slave transaction; the winning master's
// address and byte select are captured at grant and stay stable until s_ack.
// Build option: define C2C_R_ARB_RR_EN for round-robin arbitration on a tie;
// left undefined, m1 (LSU) always wins a tie and no pointer register exists.
module c2c_r_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    // master 0 (IFU)
    input  logic              m0_re,
    input  logic [XLEN/8-1:0] m0_sel,
    input  logic [XLEN-1:0]   m0_addr,
    output logic              m0_ack,
    output logic [XLEN-1:0]   m0_data,
    // master 1 (LSU)
    input  logic              m1_re,
    input  logic [XLEN/8-1:0] m1_sel,
    input  logic [XLEN-1:0]   m1_addr,
    output logic              m1_ack,
    output logic [XLEN-1:0]   m1_data,
    // slave
    output logic              s_re,
    output logic [XLEN/8-1:0] s_sel,
    output logic [XLEN-1:0]   s_addr,
    input  logic              s_ack,
    input  logic [XLEN-1:0]   s_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state_q;
    logic              s_re_q;
    logic [XLEN/8-1:0] s_sel_q;
    logic [XLEN-1:0]   s_addr_q;
    logic              pick1;

`ifdef C2C_R_ARB_RR_EN
    // Pointer names the master holding tie priority: 0 = m0, 1 = m1.
    logic              rr_q;

    // Winner selection in IDLE: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        pick1 = m1_re & (~m0_re | rr_q);
    end
`else
    // Winner selection in IDLE: m1 wins whenever it requests.
    always_comb begin
        pick1 = m1_re;
    end
`endif

    // Arbitration FSM with registered slave-side outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            s_re_q   <= 1'b0;
            s_sel_q  <= '0;
            s_addr_q <= '0;
`ifdef C2C_R_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_re || m1_re) begin
                        s_re_q <= 1'b1;
                        if (pick1) begin
                            state_q  <= GRANT1;
                            s_addr_q <= m1_addr;
                            s_sel_q  <= m1_sel;
                        end else begin
                            state_q  <= GRANT0;
                            s_addr_q <= m0_addr;
                            s_sel_q  <= m0_sel;
                        end
`ifdef C2C_R_ARB_RR_EN
                        // Pointer moves on grant, to the master just passed over.
                        rr_q <= ~pick1;
`endif
                    end
                end
                GRANT0, GRANT1: begin
                    // Completion is keyed on s_ack alone, so an abandoned
                    // request still drains the slave transaction.
                    if (s_ack) begin
                        state_q <= IDLE;
                        s_re_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    s_re_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_re   = s_re_q;
    assign s_sel  = s_sel_q;
    assign s_addr = s_addr_q;

    // Return path: ack/data routed only to the granted master, ack gated by its re.
    always_comb begin
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        m0_data = '0;
        m1_data = '0;
        if (s_ack) begin
            if (state_q == GRANT0) begin
                m0_ack  = m0_re;
                m0_data = s_data;
            end else if (state_q == GRANT1) begin
                m1_ack  = m1_re;
                m1_data = s_data;
            end
        end
    end

endmodule
